// File: rtl/aes_sh_ct_out_buffer.sv
// aes_sh_ct_out_buffer
// Purpose: buffers masked AES-128 ciphertext sharings from the round core in a
// small FIFO of whole blocks. Each block is streamed out as four 32-bit masked
// words (ciphertext bits 127:96 first) over a valid/ready handshake. Entries
// are zeroed share-wise once they are drained.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cipher_valid      one-cycle capture strobe from the AES core
//   sh_ciphertext     128*d masked ciphertext, shares of bit i at [i*d +: d]
//   space_avail       at least one free entry (gates the core's valid_in)
//   out_valid/ready   output word handshake
//   out_sh_word       32*d masked word, zero while out_valid is low
//   out_last          fourth word of a block
//   fill_level        occupied entries (0..DEPTH)
//   overflow          sticky dropped-block flag, cleared by clr_overflow
// Optional: defining AES_SH_CT_UNMASK_OUT_EN adds out_word, the registered
// share recombination of the current word (debug/KAT only).
module aes_sh_ct_out_buffer #(
    parameter int unsigned d     = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cipher_valid,
    input  logic [128*d-1:0]  sh_ciphertext,
    output logic              space_avail,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*d-1:0]   out_sh_word,
    output logic              out_last,
    output logic [2:0]        fill_level,
    output logic              overflow,
    input  logic              clr_overflow
`ifdef AES_SH_CT_UNMASK_OUT_EN
    ,
    output logic [31:0]       out_word
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BLK_W = 128 * d;
    localparam int unsigned WRD_W = 32 * d;

    logic [BLK_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [1:0]       r_beat;
    logic [2:0]       r_fill;
    logic             r_ovf;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_space;
    logic [WRD_W-1:0] r_word;

    logic [BLK_W-1:0] w_mem_nxt [DEPTH];
    logic [BLK_W-1:0] w_entry;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [1:0]       w_beat_nxt;
    logic [2:0]       w_fill_nxt;
    logic             w_ovf_nxt;
    logic [WRD_W-1:0] w_word_nxt;
    logic             w_xfer;
    logic             w_pop;
    logic             w_full;
    logic             w_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state: handshake, zero-on-pop, capture (capture overrides zeroing
    // when both hit the same entry), occupancy and overflow.
    always_comb begin
        w_mem_nxt  = r_mem;
        w_wr_nxt   = r_wr;
        w_rd_nxt   = r_rd;
        w_beat_nxt = r_beat;
        w_fill_nxt = r_fill;
        w_ovf_nxt  = r_ovf;
        w_word_nxt = '0;

        w_xfer = (r_fill != 3'd0) && out_ready;
        w_pop  = w_xfer && (r_beat == 2'd3);
        w_full = (r_fill == 3'(DEPTH));
        w_push = cipher_valid && (!w_full || w_pop);

        if (w_xfer) begin
            w_beat_nxt = r_beat + 2'd1;
        end
        if (w_pop) begin
            w_mem_nxt[r_rd] = '0;
            w_rd_nxt        = ptr_inc(r_rd);
        end
        if (w_push) begin
            w_mem_nxt[r_wr] = sh_ciphertext;
            w_wr_nxt        = ptr_inc(r_wr);
        end

        case ({w_push, w_pop})
            2'b10:   w_fill_nxt = r_fill + 3'd1;
            2'b01:   w_fill_nxt = r_fill - 3'd1;
            default: w_fill_nxt = r_fill;
        endcase

        // Set has priority over clear.
        if (clr_overflow) begin
            w_ovf_nxt = 1'b0;
        end
        if (cipher_valid && !w_push) begin
            w_ovf_nxt = 1'b1;
        end

        // Word that becomes current after this edge.
        w_entry = w_mem_nxt[w_rd_nxt];
        if (w_fill_nxt != 3'd0) begin
            case (w_beat_nxt)
                2'd0:    w_word_nxt = w_entry[96*d +: WRD_W];
                2'd1:    w_word_nxt = w_entry[64*d +: WRD_W];
                2'd2:    w_word_nxt = w_entry[32*d +: WRD_W];
                default: w_word_nxt = w_entry[0    +: WRD_W];
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr        <= '0;
            r_rd        <= '0;
            r_beat      <= 2'd0;
            r_fill      <= 3'd0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_space     <= 1'b1;
            r_word      <= '0;
        end else begin
            r_mem       <= w_mem_nxt;
            r_wr        <= w_wr_nxt;
            r_rd        <= w_rd_nxt;
            r_beat      <= w_beat_nxt;
            r_fill      <= w_fill_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= (w_fill_nxt != 3'd0);
            r_out_last  <= (w_fill_nxt != 3'd0) && (w_beat_nxt == 2'd3);
            r_space     <= (w_fill_nxt < 3'(DEPTH));
            r_word      <= w_word_nxt;
        end
    end

    assign space_avail = r_space;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign out_sh_word = r_word;
    assign fill_level  = r_fill;
    assign overflow    = r_ovf;

`ifdef AES_SH_CT_UNMASK_OUT_EN
    logic [31:0] w_unmask_nxt;
    logic [31:0] r_unmask;

    // Share recombination of the upcoming word; zero word gives zero.
    always_comb begin
        w_unmask_nxt = '0;
        for (int i = 0; i < 32; i++) begin
            w_unmask_nxt[i] = ^w_word_nxt[i*d +: d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_unmask <= '0;
        end else begin
            r_unmask <= w_unmask_nxt;
        end
    end

    assign out_word = r_unmask;
`endif

endmodule

// File: tb/tb_aes_sh_ct_out_buffer.sv
module tb_aes_sh_ct_out_buffer;

    localparam int unsigned D     = 2;
    localparam int unsigned DEPTH = 2;

    logic             clk;
    logic             rst;
    logic             cipher_valid;
    logic [128*D-1:0] sh_ciphertext;
    logic             space_avail;
    logic             out_valid;
    logic             out_ready;
    logic [32*D-1:0]  out_sh_word;
    logic             out_last;
    logic [2:0]       fill_level;
    logic             overflow;
    logic             clr_overflow;

    int n_checks = 0;
    int n_errors = 0;

    aes_sh_ct_out_buffer #(.d(D), .DEPTH(DEPTH)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cipher_valid (cipher_valid),
        .sh_ciphertext(sh_ciphertext),
        .space_avail  (space_avail),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sh_word  (out_sh_word),
        .out_last     (out_last),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0]      ct;
        logic [127:0]      mask;
        logic [3:0][31:0]  w;   // w[k] = expected recombined beat k
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // share0 = ct ^ mask, share1 = mask, interleaved per bit.
    function automatic logic [255:0] share(input logic [127:0] ct, input logic [127:0] m);
        logic [255:0] s;
        for (int i = 0; i < 128; i++) begin
            s[2*i]   = ct[i] ^ m[i];
            s[2*i+1] = m[i];
        end
        return s;
    endfunction

    function automatic logic [31:0] unshare(input logic [63:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = w[2*i] ^ w[2*i+1];
        end
        return r;
    endfunction

    task automatic capture(input logic [127:0] ct, input logic [127:0] m);
        cipher_valid  = 1'b1;
        sh_ciphertext = share(ct, m);
        tick();
        cipher_valid  = 1'b0;
        sh_ciphertext = '0;
    endtask

    // Expects the block at the head starting at beat 0, out_ready held high.
    task automatic drain_block(input logic [127:0] ct, input logic [127:0] m,
                               input logic [3:0][31:0] w);
        logic [255:0] s;
        logic [63:0]  raw;
        s = share(ct, m);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            raw = s[(3-k)*64 +: 64];
            check($sformatf("valid_b%0d", k), 256'(out_valid), 256'(1'b1));
            check($sformatf("word_b%0d", k), 256'(unshare(out_sh_word)), 256'(w[k]));
            check($sformatf("shares_b%0d", k), 256'(out_sh_word), 256'(raw));
            check($sformatf("last_b%0d", k), 256'(out_last), 256'(k == 3));
            tick();
        end
    endtask

    function automatic logic [3:0][31:0] words_of(input logic [127:0] ct);
        logic [3:0][31:0] w;
        for (int k = 0; k < 4; k++) begin
            w[k] = ct[127 - 32*k -: 32];
        end
        return w;
    endfunction

    logic [63:0]  held;
    logic [127:0] ct_a, ct_b, ct_c, m_a, m_b, m_c;

    initial begin
        vecs[0].ct   = 128'h3925841d02dc09fbdc118597196a0b32;
        vecs[0].mask = 128'h0123456789abcdef0f1e2d3c4b5a6978;
        vecs[0].w    = {32'h196a0b32, 32'hdc118597, 32'h02dc09fb, 32'h3925841d};
        vecs[1].ct   = 128'h00112233445566778899aabbccddeeff;
        vecs[1].mask = 128'hffffffffffffffffffffffffffffffff;
        vecs[1].w    = {32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
        vecs[2].ct   = 128'hdeadbeefcafef00d0123456712345678;
        vecs[2].mask = 128'ha5a5a5a55a5a5a5a3c3c3c3cc3c3c3c3;
        vecs[2].w    = {32'h12345678, 32'h01234567, 32'hcafef00d, 32'hdeadbeef};

        rst = 1'b1; cipher_valid = 1'b0; sh_ciphertext = '0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        #12;
        check("rst_valid", 256'(out_valid), 256'(0));
        check("rst_space", 256'(space_avail), 256'(1));
        check("rst_fill", 256'(fill_level), 256'(0));
        check("rst_ovf", 256'(overflow), 256'(0));
        check("rst_word", 256'(out_sh_word), 256'(0));
        tick();
        rst = 1'b0;
        tick();

        // Table-driven single blocks.
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            capture(vecs[v].ct, vecs[v].mask);
            drain_block(vecs[v].ct, vecs[v].mask, vecs[v].w);
            check($sformatf("v%0d_fill_after", v), 256'(fill_level), 256'(0));
            check($sformatf("v%0d_valid_after", v), 256'(out_valid), 256'(0));
            check($sformatf("v%0d_word_idle", v), 256'(out_sh_word), 256'(0));
        end

        // Backpressure at beat 1.
        ct_a = vecs[0].ct; m_a = vecs[0].mask;
        capture(ct_a, m_a);
        tick();                     // beat 0 transferred, beat 1 current
        out_ready = 1'b0;
        held = out_sh_word;
        check("bp_beat1", 256'(unshare(held)), 256'(32'h02dc09fb));
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), 256'(out_sh_word), 256'(held));
        end
        out_ready = 1'b1;
        tick();
        check("bp_beat2", 256'(unshare(out_sh_word)), 256'(32'hdc118597));
        tick();
        check("bp_beat3", 256'(unshare(out_sh_word)), 256'(32'h196a0b32));
        check("bp_last", 256'(out_last), 256'(1));
        tick();
        check("bp_empty", 256'(out_valid), 256'(0));

        // Full and overflow.
        out_ready = 1'b0;
        ct_a = vecs[1].ct; m_a = vecs[1].mask;
        ct_b = vecs[2].ct; m_b = vecs[2].mask;
        ct_c = 128'hfeedfacefeedfacefeedfacefeedface; m_c = 128'h1;
        capture(ct_a, m_a);
        check("ovf_fill1", 256'(fill_level), 256'(1));
        check("ovf_space1", 256'(space_avail), 256'(1));
        capture(ct_b, m_b);
        check("ovf_fill2", 256'(fill_level), 256'(2));
        check("ovf_space2", 256'(space_avail), 256'(0));
        check("ovf_clear_before", 256'(overflow), 256'(0));
        capture(ct_c, m_c);
        check("ovf_set", 256'(overflow), 256'(1));
        check("ovf_fill3", 256'(fill_level), 256'(2));
        tick();
        check("ovf_sticky", 256'(overflow), 256'(1));
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_cleared", 256'(overflow), 256'(0));
        drain_block(ct_a, m_a, words_of(ct_a));
        drain_block(ct_b, m_b, words_of(ct_b));
        check("ovf_drained", 256'(fill_level), 256'(0));
        check("zero_e0", 256'(u_dut.r_mem[0]), 256'(0));
        check("zero_e1", 256'(u_dut.r_mem[1]), 256'(0));
        check("zero_word", 256'(out_sh_word), 256'(0));

        // Pop and capture together while full.
        out_ready = 1'b0;
        capture(ct_a, m_a);
        capture(ct_b, m_b);
        out_ready = 1'b1;
        tick(); tick(); tick();     // head now at beat 3
        check("pc_last", 256'(out_last), 256'(1));
        cipher_valid  = 1'b1;
        sh_ciphertext = share(ct_c, m_c);
        tick();
        cipher_valid  = 1'b0;
        sh_ciphertext = '0;
        check("pc_no_ovf", 256'(overflow), 256'(0));
        check("pc_fill", 256'(fill_level), 256'(2));
        check("pc_space", 256'(space_avail), 256'(0));
        drain_block(ct_b, m_b, words_of(ct_b));
        drain_block(ct_c, m_c, words_of(ct_c));
        check("pc_empty", 256'(fill_level), 256'(0));
        check("pc_zero_e0", 256'(u_dut.r_mem[0]), 256'(0));
        check("pc_zero_e1", 256'(u_dut.r_mem[1]), 256'(0));

        // Reset during beat 2.
        capture(ct_a, m_a);
        tick(); tick();
        check("mr_pre_word", 256'(unshare(out_sh_word)), 256'(32'h8899aabb));
        rst = 1'b1;
        #1;
        check("mr_valid", 256'(out_valid), 256'(0));
        check("mr_last", 256'(out_last), 256'(0));
        check("mr_word", 256'(out_sh_word), 256'(0));
        check("mr_space", 256'(space_avail), 256'(1));
        check("mr_fill", 256'(fill_level), 256'(0));
        tick();
        rst = 1'b0;
        tick();
        check("mr_idle", 256'(out_valid), 256'(0));
        capture(ct_b, m_b);
        drain_block(ct_b, m_b, words_of(ct_b));
        check("mr_end_fill", 256'(fill_level), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
